mitll_ndro_bank: RTL



---
 rtl/mitll_pkg.sv | 13 +
 rtl/mitll_ndro_cell.sv | 19 +
 rtl/mitll_ndro_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/mitll_pkg.sv
// Shared definitions for the NDRO storage bank: write FSM state encoding and
// the number of cycles one write occupies (accept, clear pulse, set pulse).
package mitll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        SET  = 2'd2
    } ndro_state_t;

    localparam int NDRO_WRITE_CYCLES = 3;

endpackage

// File: rtl/mitll_ndro_cell.sv
// One-bit non-destructive-readout cell. R clears, S sets, R wins when both
// are pulsed; reading Q never disturbs the stored value.
module mitll_ndro_cell (
    input  logic C,
    input  logic S,
    input  logic R,
    output logic Q
);

    // Clear has priority over set; otherwise hold.
    always_ff @(posedge C) begin
        if (R) begin
            Q <= 1'b0;
        end else if (S) begin
            Q <= 1'b1;
        end
    end

endmodule

// File: rtl/mitll_ndro_bank.sv
// DEPTH x WIDTH bank of NDRO cells. A write is a clear pulse to the whole
// entry followed by a set pulse carrying the data, so it takes two cycles
// after acceptance. Reads are registered, one-cycle latency, never stall.
// Optional build macro: MITLL_NDRO_BYPASS_EN forwards the pending write data
// to reads of the entry being written, hiding the cleared/old contents.
module mitll_ndro_bank
    import mitll_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_valid,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_data_valid
);

    ndro_state_t                  state;
    logic [AW-1:0]                pend_addr;
    logic [WIDTH-1:0]             pend_data;
    logic                         wr_accept;
    logic [DEPTH-1:0]             pend_hit;
    logic [DEPTH-1:0][WIDTH-1:0]  entry;
    logic [WIDTH-1:0]             rd_raw;
    logic [WIDTH-1:0]             rd_next;
    logic                         rd_in_range;

    assign wr_ready  = (state == IDLE) && !R;
    assign wr_accept = wr_valid && wr_ready;

    // Write sequencer: latch the request, then one clear cycle, one set cycle.
    always_ff @(posedge C) begin
        if (R) begin
            state     <= IDLE;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_accept) begin
                        pend_addr <= wr_addr;
                        pend_data <= wr_data;
                        state     <= CLR;
                    end
                end
                CLR:     state <= SET;
                SET:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Cell array. An out-of-range pend_addr matches no entry, so such a
    // write walks through CLR and SET without touching anything.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        assign pend_hit[e] = (pend_addr == AW'(e));
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            mitll_ndro_cell u_cell (
                .C (C),
                .S ((state == SET) && pend_hit[e] && pend_data[b]),
                .R (R || ((state == CLR) && pend_hit[e])),
                .Q (entry[e][b])
            );
        end
    end

    // Read mux over the pre-edge array contents; unmatched addresses give 0.
    always_comb begin
        rd_raw = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (rd_addr == AW'(e)) begin
                rd_raw = entry[e];
            end
        end
    end

    assign rd_in_range = (int'(rd_addr) < DEPTH);

    // Select the value a read returns, optionally forwarding pending data.
    always_comb begin
        rd_next = rd_raw;
`ifdef MITLL_NDRO_BYPASS_EN
        if (rd_in_range) begin
            if (wr_accept && (rd_addr == wr_addr)) begin
                rd_next = wr_data;
            end else if ((state != IDLE) && (rd_addr == pend_addr)) begin
                rd_next = pend_data;
            end
        end else begin
            rd_next = '0;
        end
`else
        if (!rd_in_range) begin
            rd_next = '0;
        end
`endif
    end

    // Registered read port: one result per request, valid for one cycle.
    always_ff @(posedge C) begin
        if (R) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_valid;
            if (rd_valid) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule
